// File: rtl/video_load_sequencer_if.sv
// Memory read port and shifter load bus of the video load sequencer.
// master = sequencer side, slave = memory/shifter side.
interface video_load_sequencer_if #(
    parameter int ADDR_W = 23
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [15:0]       mem_data;
    logic              load_n;
    logic [15:0]       shifter_data;

    modport master (
        output mem_req, mem_addr, load_n, shifter_data,
        input  mem_ack, mem_data
    );

    modport slave (
        input  mem_req, mem_addr, load_n, shifter_data,
        output mem_ack, mem_data
    );
endinterface

// File: rtl/video_load_sequencer.sv
// Video load sequencer: fetches one display word per 16-clock slot and strobes it into the shifter.
// Optional macro VIDEO_LINE_OFFSET_EN adds line_offset, added to the address counter on each de fall.
module video_load_sequencer #(
    parameter int ADDR_W     = 23,
    parameter int LOAD_PHASE = 8,
    parameter int LOAD_LEN   = 4
) (
    input  logic                   CLOCK_32,
    input  logic                   reset,
    input  logic                   de,
    input  logic                   vsync,
    input  logic [ADDR_W-1:0]      video_base,
`ifdef VIDEO_LINE_OFFSET_EN
    input  logic [7:0]             line_offset,
`endif
    input  logic                   underrun_clr,
    output logic [ADDR_W-1:0]      video_addr,
    output logic                   underrun,
    video_load_sequencer_if.master bus
);

    localparam logic [3:0] FETCH_LAST = 4'd7;
    localparam logic [3:0] LOAD_START = 4'(LOAD_PHASE - 1);
    localparam logic [3:0] LOAD_END   = 4'(LOAD_PHASE + LOAD_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HOLD,
        ST_LOAD
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_phase;
    logic [1:0]        r_de_sr;
    logic [1:0]        r_vs_sr;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_next;
    logic [15:0]       r_hold;
    logic [15:0]       w_hold_next;
    logic [15:0]       r_shifter;
    logic              r_underrun;
    logic              w_de_sync;
    logic              w_vs_rise;
    logic              w_ack;
    logic              w_miss;
    logic              w_fetch_done;
    logic              w_load_start;

    assign w_de_sync    = r_de_sr[1];
    assign w_vs_rise    = (r_vs_sr == 2'b01);
    assign w_ack        = (r_state == ST_FETCH) && bus.mem_ack;
    assign w_miss       = (r_state == ST_FETCH) && !bus.mem_ack && (r_phase == FETCH_LAST);
    assign w_fetch_done = w_ack || w_miss;
    assign w_load_start = (w_state_next == ST_LOAD) && (r_state != ST_LOAD);

    // Slot arming happens on the edge into phase 0, so every slot starts from a clean state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FETCH: begin
                if (w_fetch_done) begin
                    w_state_next = (r_phase == LOAD_START) ? ST_LOAD : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_phase == LOAD_START) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (r_phase == LOAD_END) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (r_phase == 4'd15) begin
            w_state_next = w_de_sync ? ST_FETCH : ST_IDLE;
        end
    end

    always_comb begin
        w_hold_next = r_hold;
        if (w_ack) begin
            w_hold_next = bus.mem_data;
        end else if (w_miss) begin
            w_hold_next = 16'h0000;
        end
    end

    // A vsync rise overrides any same-cycle advance; the advance is simply lost.
    always_comb begin
        w_addr_next = r_addr;
        if (w_vs_rise) begin
            w_addr_next = video_base;
        end else begin
            w_addr_next = r_addr + ADDR_W'(w_fetch_done);
`ifdef VIDEO_LINE_OFFSET_EN
            if (r_de_sr == 2'b10) begin
                w_addr_next = w_addr_next + ADDR_W'(line_offset);
            end
`endif
        end
    end

    always_ff @(posedge CLOCK_32) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_phase    <= 4'd0;
            r_de_sr    <= 2'b00;
            r_vs_sr    <= 2'b00;
            r_addr     <= '0;
            r_hold     <= 16'h0000;
            r_shifter  <= 16'h0000;
            r_underrun <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_phase <= r_phase + 4'd1;
            r_de_sr <= {r_de_sr[0], de};
            r_vs_sr <= {r_vs_sr[0], vsync};
            r_addr  <= w_addr_next;
            r_hold  <= w_hold_next;
            if (w_load_start) begin
                r_shifter <= w_hold_next;
            end
            if (w_miss) begin
                r_underrun <= 1'b1;
            end else if (underrun_clr) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign bus.mem_req      = (r_state == ST_FETCH);
    assign bus.mem_addr     = r_addr;
    assign bus.load_n       = (r_state != ST_LOAD);
    assign bus.shifter_data = r_shifter;
    assign video_addr       = r_addr;
    assign underrun         = r_underrun;

endmodule

// File: tb/tb_video_load_sequencer.sv
// Self-checking bench for video_load_sequencer: slot-level reference model, directed and random slots.
`timescale 1ns/1ps
module tb_video_load_sequencer;
    localparam int ADDR_W = 23;

    logic              clk = 1'b0;
    logic              rst;
    logic              de;
    logic              vsync;
    logic              underrun_clr;
    logic [ADDR_W-1:0] video_base;
    logic [ADDR_W-1:0] video_addr;
    logic              underrun;
`ifdef VIDEO_LINE_OFFSET_EN
    logic [7:0]        line_offset = 8'd0;
`endif

    video_load_sequencer_if #(.ADDR_W(ADDR_W)) bus_if ();

    video_load_sequencer #(.ADDR_W(ADDR_W), .LOAD_PHASE(8), .LOAD_LEN(4)) dut (
        .CLOCK_32     (clk),
        .reset        (rst),
        .de           (de),
        .vsync        (vsync),
        .video_base   (video_base),
`ifdef VIDEO_LINE_OFFSET_EN
        .line_offset  (line_offset),
`endif
        .underrun_clr (underrun_clr),
        .video_addr   (video_addr),
        .underrun     (underrun),
        .bus          (bus_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int ph     = 0;

    // observations of one slot (bit p = value during phase p)
    logic [15:0]       o_req, o_load, o_sdata;
    logic [ADDR_W-1:0] o_addr0, o_vaddr;
    logic              o_unr;

    // reference model state and per-slot expectations
    logic [ADDR_W-1:0] m_cnt;
    logic              m_unr;
    logic [15:0]       m_word;
    logic [15:0]       e_req, e_load, e_word;
    logic [ADDR_W-1:0] e_addr0;

    task automatic tick();
        @(posedge clk);
        #1;
        ph = (ph + 1) % 16;
    endtask

    // Predicts one slot from the behavioural rules: fetch window 0..7, load low 8..11,
    // counter advances once per active slot, vsync reload ordered against the fetch end.
    task automatic model_slot(input bit active, input int ack_ph, input logic [15:0] data,
                              input int vs_ph, input logic [ADDR_W-1:0] base, input int clr_ph);
        int done_ph;
        bit miss;
        done_ph = (ack_ph >= 0) ? ack_ph : 7;
        miss    = active && (ack_ph < 0);
        e_addr0 = m_cnt;
        if (active) begin
            e_req  = 16'((32'd1 << (done_ph + 1)) - 32'd1);
            e_load = 16'hF0FF;
            m_word = (ack_ph >= 0) ? data : 16'h0000;
        end else begin
            e_req  = 16'h0000;
            e_load = 16'hFFFF;
        end
        e_word = m_word;
        if (vs_ph >= 0)
            m_cnt = (active && vs_ph < done_ph) ? base + 23'd1 : base;
        else if (active)
            m_cnt = m_cnt + 23'd1;
        if (miss)
            m_unr = (clr_ph > 7) ? 1'b0 : 1'b1;
        else if (clr_ph >= 0)
            m_unr = 1'b0;
    endtask

    // Drives one 16-clock slot starting at phase 0 and records what the DUT shows.
    task automatic drive_slot(input int ack_ph, input logic [15:0] data, input int vs_ph,
                              input int clr_ph, input int de_fall_ph, input int stray_ph);
        o_req  = '0;
        o_load = '0;
        for (int p = 0; p < 16; p++) begin
            o_req[p]  = bus_if.mem_req;
            o_load[p] = bus_if.load_n;
            if (p == 0) o_addr0 = bus_if.mem_addr;
            if (p == 8) o_sdata = bus_if.shifter_data;
            bus_if.mem_ack  = (p == ack_ph) || (p == stray_ph);
            bus_if.mem_data = (p == ack_ph) ? data : 16'($urandom);
            if (p == vs_ph - 1) vsync = 1'b1;
            if (p == 15) vsync = 1'b0;
            underrun_clr = (p == clr_ph);
            if (p == de_fall_ph) de = 1'b0;
            tick();
        end
        bus_if.mem_ack = 1'b0;
        underrun_clr   = 1'b0;
        o_vaddr = video_addr;
        o_unr   = underrun;
        $display("slot ack=%0d vs=%0d req=%h load=%h addr0=%h sdata=%h vaddr=%h unr=%b",
                 ack_ph, vs_ph, o_req, o_load, o_addr0, o_sdata, o_vaddr, o_unr);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        de = 1'b0; vsync = 1'b0; underrun_clr = 1'b0; video_base = '0;
        bus_if.mem_ack = 1'b0; bus_if.mem_data = 16'h0000;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        ph = 0;
        m_cnt = '0; m_unr = 1'b0; m_word = 16'h0000;
        checks++; if (bus_if.load_n !== 1'b1) begin errors++; $display("FAIL reset_load_n got %b want 1", bus_if.load_n); end
        checks++; if (bus_if.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", bus_if.mem_req); end
        checks++; if (bus_if.shifter_data !== 16'h0000) begin errors++; $display("FAIL reset_shifter_data got %h want 0000", bus_if.shifter_data); end
        checks++; if (video_addr !== 23'h0) begin errors++; $display("FAIL reset_video_addr got %h want 0", video_addr); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b want 0", underrun); end
    endtask

    task automatic test_first_word();
        de = 1'b1;
        video_base = 23'h03C000;
        model_slot(1'b0, -1, 16'h0, 3, video_base, -1);
        drive_slot(-1, 16'h0, 3, -1, -1, -1);
        checks++; if (o_req !== 16'h0000) begin errors++; $display("FAIL first_idle_req got %h want 0000", o_req); end
        checks++; if (o_vaddr !== 23'h03C000) begin errors++; $display("FAIL first_vsync_load got %h want 03c000", o_vaddr); end
        model_slot(1'b1, 2, 16'hA5A5, -1, video_base, -1);
        drive_slot(2, 16'hA5A5, -1, -1, -1, -1);
        checks++; if (o_addr0 !== 23'h03C000) begin errors++; $display("FAIL first_mem_addr got %h want 03c000", o_addr0); end
        checks++; if (o_req !== 16'h0007) begin errors++; $display("FAIL first_req got %h want 0007", o_req); end
        checks++; if (o_load !== 16'hF0FF) begin errors++; $display("FAIL first_load got %h want f0ff", o_load); end
        checks++; if (o_sdata !== 16'hA5A5) begin errors++; $display("FAIL first_sdata got %h want a5a5", o_sdata); end
        checks++; if (o_vaddr !== 23'h03C001) begin errors++; $display("FAIL first_vaddr got %h want 03c001", o_vaddr); end
    endtask

    task automatic test_burst();
        logic [ADDR_W-1:0] start;
        logic [15:0] d;
        int a;
        start = m_cnt;
        for (int n = 1; n <= 4; n++) begin
            d = 16'(n * 16'h1111);
            a = $urandom_range(0, 7);
            model_slot(1'b1, a, d, -1, video_base, -1);
            drive_slot(a, d, -1, -1, -1, -1);
            checks++; if (o_sdata !== d || o_load !== 16'hF0FF) begin errors++; $display("FAIL burst_word%0d got %h/%h want %h/f0ff", n, o_sdata, o_load, d); end
        end
        checks++; if (o_vaddr !== start + 23'd4) begin errors++; $display("FAIL burst_count got %h want %h", o_vaddr, start + 23'd4); end
    endtask

    task automatic test_underrun();
        logic [ADDR_W-1:0] start;
        start = m_cnt;
        model_slot(1'b1, -1, 16'h0, -1, video_base, -1);
        drive_slot(-1, 16'h0, -1, -1, -1, 12);
        checks++; if (o_req !== 16'h00FF) begin errors++; $display("FAIL miss_req got %h want 00ff", o_req); end
        checks++; if (o_sdata !== 16'h0000 || o_load !== 16'hF0FF) begin errors++; $display("FAIL miss_load got %h/%h want 0000/f0ff", o_sdata, o_load); end
        checks++; if (o_unr !== 1'b1) begin errors++; $display("FAIL miss_flag got %b want 1", o_unr); end
        checks++; if (o_vaddr !== start + 23'd1) begin errors++; $display("FAIL miss_count got %h want %h", o_vaddr, start + 23'd1); end
        model_slot(1'b1, 3, 16'h5A5A, -1, video_base, 10);
        drive_slot(3, 16'h5A5A, -1, 10, -1, -1);
        checks++; if (o_unr !== 1'b0) begin errors++; $display("FAIL underrun_clr got %b want 0", o_unr); end
        model_slot(1'b1, -1, 16'h0, -1, video_base, 7);
        drive_slot(-1, 16'h0, -1, 7, -1, -1);
        checks++; if (o_unr !== 1'b1) begin errors++; $display("FAIL miss_beats_clr got %b want 1", o_unr); end
    endtask

    task automatic test_vsync_collision();
        video_base = 23'h000010;
        model_slot(1'b1, 5, 16'h0F0F, 9, video_base, -1);
        drive_slot(5, 16'h0F0F, 9, -1, -1, -1);
        checks++; if (o_vaddr !== m_cnt) begin errors++; $display("FAIL vs_after_ack got %h want %h", o_vaddr, m_cnt); end
        video_base = 23'h000200;
        model_slot(1'b1, 4, 16'hC3C3, 4, video_base, -1);
        drive_slot(4, 16'hC3C3, 4, -1, -1, -1);
        checks++; if (o_addr0 !== 23'h000010) begin errors++; $display("FAIL vs_coll_addr got %h want 000010", o_addr0); end
        checks++; if (o_vaddr !== 23'h000200) begin errors++; $display("FAIL vs_coll_vaddr got %h want 000200", o_vaddr); end
        checks++; if (o_load !== 16'hF0FF || o_sdata !== 16'hC3C3) begin errors++; $display("FAIL vs_coll_load got %h/%h want f0ff/c3c3", o_load, o_sdata); end
    endtask

    task automatic test_de_fall();
        logic [ADDR_W-1:0] held;
        model_slot(1'b1, 3, 16'h7E7E, -1, video_base, -1);
        drive_slot(3, 16'h7E7E, -1, -1, 5, -1);
        checks++; if (o_load !== 16'hF0FF || o_sdata !== 16'h7E7E) begin errors++; $display("FAIL de_fall_slot got %h/%h want f0ff/7e7e", o_load, o_sdata); end
        held = m_cnt;
        de = 1'b1;
        model_slot(1'b0, -1, 16'h0, -1, video_base, -1);
        drive_slot(-1, 16'h0, -1, -1, -1, 2);
        checks++; if (o_req !== 16'h0000) begin errors++; $display("FAIL de_off_req got %h want 0000", o_req); end
        checks++; if (o_load !== 16'hFFFF) begin errors++; $display("FAIL de_off_load got %h want ffff", o_load); end
        checks++; if (o_vaddr !== held) begin errors++; $display("FAIL de_off_count got %h want %h", o_vaddr, held); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            bit act;
            int a, vs, clr, stray;
            logic [15:0] d;
            act = de;
            de = ($urandom_range(0, 3) != 0);
            d = 16'($urandom);
            video_base = 23'($urandom);
            vs  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 14)) : -1;
            clr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
            if (act) begin
                a = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 7));
                stray = (a >= 0) ? int'($urandom_range(a + 1, 15)) : int'($urandom_range(8, 15));
            end else begin
                a = -1;
                stray = $urandom_range(0, 15);
            end
            model_slot(act, a, d, vs, video_base, clr);
            drive_slot(a, d, vs, clr, -1, stray);
            checks++; if (o_req !== e_req) begin errors++; $display("FAIL rnd%0d_req got %h want %h", n, o_req, e_req); end
            checks++; if (o_load !== e_load) begin errors++; $display("FAIL rnd%0d_load got %h want %h", n, o_load, e_load); end
            checks++; if (o_addr0 !== e_addr0) begin errors++; $display("FAIL rnd%0d_addr got %h want %h", n, o_addr0, e_addr0); end
            checks++; if (o_sdata !== e_word) begin errors++; $display("FAIL rnd%0d_sdata got %h want %h", n, o_sdata, e_word); end
            checks++; if (o_vaddr !== m_cnt) begin errors++; $display("FAIL rnd%0d_vaddr got %h want %h", n, o_vaddr, m_cnt); end
            checks++; if (o_unr !== m_unr) begin errors++; $display("FAIL rnd%0d_underrun got %b want %b", n, o_unr, m_unr); end
        end
    endtask

    task automatic test_reset_mid_slot();
        de = 1'b1;
        drive_slot(1, 16'h1234, -1, -1, -1, -1);
        bus_if.mem_ack = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        checks++; if (bus_if.load_n !== 1'b0) begin errors++; $display("FAIL midslot_load_low got %b want 0", bus_if.load_n); end
        rst = 1'b1;
        tick();
        checks++; if (bus_if.load_n !== 1'b1) begin errors++; $display("FAIL midslot_rst_load_n got %b want 1", bus_if.load_n); end
        checks++; if (bus_if.mem_req !== 1'b0) begin errors++; $display("FAIL midslot_rst_req got %b want 0", bus_if.mem_req); end
        checks++; if (underrun !== 1'b0 || video_addr !== 23'h0) begin errors++; $display("FAIL midslot_rst_state got %b/%h want 0/0", underrun, video_addr); end
        rst = 1'b0;
        ph = 0;
        m_cnt = '0; m_unr = 1'b0; m_word = 16'h0000;
        model_slot(1'b0, -1, 16'h0, -1, video_base, -1);
        drive_slot(-1, 16'h0, -1, -1, -1, 3);
        checks++; if (o_req !== e_req || o_load !== e_load) begin errors++; $display("FAIL post_rst_idle got %h/%h want %h/%h", o_req, o_load, e_req, e_load); end
        model_slot(1'b1, 6, 16'hBEEF, -1, video_base, -1);
        drive_slot(6, 16'hBEEF, -1, -1, -1, -1);
        checks++; if (o_req !== e_req) begin errors++; $display("FAIL post_rst_phase got %h want %h", o_req, e_req); end
        checks++; if (o_sdata !== 16'hBEEF || o_vaddr !== 23'd1) begin errors++; $display("FAIL post_rst_word got %h/%h want beef/000001", o_sdata, o_vaddr); end
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_burst();
        test_underrun();
        test_vsync_collision();
        test_de_fall();
        test_random();
        test_reset_mid_slot();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
